// File: rtl/mm_wb_pkg.sv
// Shared types for the posted write buffer: FSM states, buffered entry layout and line geometry.
package mm_wb_pkg;

  localparam int unsigned LINE_LSB = 5;
  localparam int unsigned LINE_W   = 32 - LINE_LSB;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrGap,
    StRdIssue,
    StRdWait
  } wb_state_e;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [31:0]       be;
    logic [255:0]      wd;
  } wb_entry_t;

  // Byte address of the first byte of a line.
  function automatic logic [31:0] line_addr(input logic [LINE_W-1:0] line);
    return {line, {LINE_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order entry queue for the write buffer, with a per-entry line compare for read hazards.
module wb_fifo
  import mm_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head_entry,
  output logic              full,
  output logic              empty,
  input  logic [LINE_W-1:0] match_line,
  output logic [DEPTH-1:0]  match_vec
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] head_q;
  logic [PtrW-1:0] tail_q;
  logic [CntW-1:0] count_q;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PtrW-1:0] offs;
    assign offs          = PtrW'(gi) - head_q;
    assign match_vec[gi] = ({1'b0, offs} < count_q) && (mem_q[gi].line == match_line);
  end

  // Flow control upstream must never overrun or underrun the queue.
  assert property (@(posedge clk) disable iff (!reset) !(push && full));
  assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/mm_write_buffer.sv
// Posted write buffer between the cache miss/evict port and main memory.
// Writes are queued and drained in order at the memory write rate; line-fill reads
// bypass queued writes unless a queued write targets the same line.
module mm_write_buffer
  import mm_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WRITE_TPUT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  a,
  input  logic [31:0]  be,
  input  logic [255:0] wd,
  input  logic         read,
  input  logic         write,
  output logic         ready,
  output logic [255:0] rd,
  output logic         rd_valid,
  output logic [31:0]  mm_a,
  output logic [31:0]  mm_be,
  output logic [255:0] mm_wd,
  output logic         mm_write,
  output logic         mm_read,
  input  logic [255:0] mm_rd,
  input  logic         mm_valid
);

  // Gap counter holds WRITE_TPUT-2 down to 0, i.e. WRITE_TPUT-1 cycles in StWrGap.
  localparam int unsigned   GapW    = (WRITE_TPUT > 2) ? $clog2(WRITE_TPUT - 1) : 1;
  localparam logic [GapW-1:0] GapLoad = (WRITE_TPUT > 1) ? GapW'(WRITE_TPUT - 2) : '0;

  wb_state_e         state_q, state_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_hold_q, rd_hold_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;

  logic              full, empty;
  logic              push_en, pop_en, rd_acc, hazard;
  logic [LINE_W-1:0] req_line;
  logic [DEPTH-1:0]  match_vec;
  wb_entry_t         push_entry, head_entry;
  logic              unused_a_lsb;

  assign req_line     = a[31:LINE_LSB];
  assign unused_a_lsb = ^a[LINE_LSB-1:0];

  assign ready   = !full && !rd_pend_q;
  assign push_en = write && ready;
  assign rd_acc  = read && ready;
  // A same-cycle write shares the request address, so it always matches the read.
  assign hazard  = (|match_vec) || push_en;

  assign push_entry = '{line: req_line, be: be, wd: wd};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_en),
    .push_entry (push_entry),
    .pop        (pop_en),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .match_line (req_line),
    .match_vec  (match_vec)
  );

  // FSM, gap counter and pending-read latch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gap_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_hold_q <= 1'b0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      rd_pend_q <= rd_pend_d;
      rd_hold_q <= rd_hold_d;
      rd_line_q <= rd_line_d;
    end
  end

  // Next state: a non-held read wins in idle; a held read waits until the queue is empty.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q && !(rd_hold_q && !empty)) begin
          state_d = StRdIssue;
        end else if (!empty) begin
          state_d = StWrIssue;
        end
      end
      StWrIssue: begin
        pop_en = 1'b1;
        if (WRITE_TPUT > 1) begin
          state_d = StWrGap;
          gap_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StWrGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        if (mm_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read latch: capture on accept, release when fill data returns.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_hold_d = rd_hold_q;
    rd_line_d = rd_line_q;
    if (rd_acc) begin
      rd_pend_d = 1'b1;
      rd_hold_d = hazard;
      rd_line_d = req_line;
    end else if ((state_q == StRdWait) && mm_valid) begin
      rd_pend_d = 1'b0;
      rd_hold_d = 1'b0;
    end
  end

  // Memory-side outputs are zero outside the issue cycles.
  always_comb begin
    mm_write = 1'b0;
    mm_read  = 1'b0;
    mm_a     = '0;
    mm_be    = '0;
    mm_wd    = '0;
    unique case (state_q)
      StWrIssue: begin
        mm_write = 1'b1;
        mm_a     = line_addr(head_entry.line);
        mm_be    = head_entry.be;
        mm_wd    = head_entry.wd;
      end
      StRdIssue: begin
        mm_read = 1'b1;
        mm_a    = line_addr(rd_line_q);
        mm_be   = '1;
      end
      default: ;
    endcase
  end

  assign rd       = mm_rd;
  assign rd_valid = mm_valid && (state_q == StRdWait);

endmodule

// File: doc/mm_write_buffer.md
# mm_write_buffer

Posted write buffer between the L1 `cache` miss/eviction port and `mainmemory`. Absorbs 256-bit line writes into a small in-order FIFO, drains them to memory at the memory's write throughput, and forwards line-fill reads, giving reads priority unless a buffered write to the same line must land first. Cache-side ports mirror the cache's `mm_*` master port. Memory-side ports drive `mainmemory` unchanged.

## Interface
- `DEPTH`, 4: buffer entries (power of two, ≥2).
- `WRITE_TPUT`, 4: minimum cycles between successive `mm_write` pulses (≥1).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `a` input 32: cache request byte address; line address is `a[31:5]`.
- `be` input 32: byte enables for write.
- `wd` input 256: write line data.
- `read` input 1: line-fill read request.
- `write` input 1: line write request.
- `ready` output 1: request accepted this cycle when high.
- `rd` output 256: fill data (equals `mm_rd`).
- `rd_valid` output 1: fill data valid, one cycle.
- `mm_a` output 32: memory address, `{line,5'b0}`.
- `mm_be` output 32: memory byte enables (all ones on reads).
- `mm_wd` output 256: memory write data.
- `mm_write` output 1: one-cycle write pulse.
- `mm_read` output 1: one-cycle read pulse.
- `mm_rd` input 256: memory read data.
- `mm_valid` input 1: memory read data valid.

## Operation
- `ready = !full & !rd_pend`. Write accepted when `write & ready` and enqueued at tail. Read accepted when `read & ready` and latched as `rd_pend` with line address. A request while `!ready` is ignored. The requester holds it.
- Simultaneous accepted read and write: the write is enqueued first. The hazard check includes it.
- Hazard: a pending read whose line matches any valid entry (the tail write in the same cycle counts) sets `rd_hold`. The read issues only after the buffer has drained through the youngest matching entry. The implementation drains the entire buffer.
- FSM states:
  - IDLE: if `rd_pend & !rd_hold`, go to RD_ISSUE. Else if not empty, go to WR_ISSUE.
  - WR_ISSUE: `mm_write=1` with head entry. Pop. If `WRITE_TPUT>1`, go to WR_GAP. Else go to IDLE.
  - WR_GAP: counts `WRITE_TPUT-1` cycles, then goes to IDLE.
  - RD_ISSUE: `mm_read=1`, `mm_be=32'hFFFF_FFFF`. Go to RD_WAIT.
  - RD_WAIT: on `mm_valid`, clear `rd_pend`/`rd_hold` and go to IDLE.
- `rd = mm_rd` combinationally. `rd_valid = mm_valid & (state==RD_WAIT)`. `mm_valid` in other states is ignored.
- Arbitration in IDLE: a non-held read beats buffered writes. Writes drain strictly in order. No coalescing; duplicate lines are enqueued separately.
- `mm_a`/`mm_be`/`mm_wd` are driven only during issue cycles and are 0 otherwise.
- Full: `count==DEPTH` drops `ready`. A pop and a push in the same cycle keep count. `ready` is computed from the registered count, before the pop. Pointers wrap modulo `DEPTH`. Count width is `$clog2(DEPTH)+1`.
- Reset (async, any time): FIFO emptied, pointers/count 0, `rd_pend`=0, state IDLE. In-flight memory read data after reset is ignored.

## Timing
- Reset values: `ready`=1 after reset release; `rd_valid`, `mm_write`, `mm_read`, `mm_a`, `mm_be`, `mm_wd`=0.
- Write accepted at edge N into an empty, idle buffer: `mm_write` high in cycle N+1. The next buffered write pulses no earlier than N+1+`WRITE_TPUT`.
- Read accepted at edge N, no hazard, idle: `mm_read` high in cycle N+1. `rd_valid` is coincident with `mm_valid` (memory READ_LAT later).
- A read arriving during WR_GAP issues in the first cycle after the gap ends.
- Hazarded read: `mm_read` is asserted no earlier than the cycle after the WR_GAP that follows the last drained write.

## Structure
- Package `mm_wb_pkg`: FSM state enum (IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_WAIT), entry struct {line[26:0], be[31:0], wd[255:0]}, `LINE_LSB=5`.
- Sub-module `wb_fifo`: storage, head/tail/count, push/pop, full/empty, and a per-entry line-match vector for the hazard compare.
- The top holds the FSM, gap counter, and read latch.

## Test plan
- Reset mid-drain: enqueue 3 writes, assert `reset`=0 during WR_GAP. Required: `mm_write`=0 immediately, `ready`=1 after release, no further writes issued.
- Single write: write `a=32'h0000_0040`, `wd` pattern 0xA5…, `be` all ones. Required: one `mm_write` pulse next cycle with `mm_a=32'h40`. `WRITE_TPUT`=4 spacing holds for a second write.
- Fill to full: 4 back-to-back writes with the memory gap active. Required: `ready`=0 after the 4th. A 5th held write is accepted only after the first pop. Memory receives lines in enqueue order.
- Read priority: 2 buffered writes to 0x100 and 0x120, then read 0x200. Required: `mm_read` issues before the second write. `rd_valid` returns `mm_rd` data.
- RAW hazard: buffered write to 0x300, read 0x300 in the next cycle. Required: `mm_write` to 0x300 precedes `mm_read`. Read data equals the written line.
- Same-cycle read and write to 0x400: required: write drains first, then read. `ready`=0 until `rd_valid`.
